// File: rtl/fp_normalizer_pkg.sv
// Shared types and constants for the fixed-width magnitude normalizer.
package fp_normalizer_pkg;

  localparam int MAG_W  = 12;
  localparam int EXP_W  = 3;
  localparam int SIG_W  = 4;
  localparam int LZ_CAP = 8;
  localparam int CNT_W  = 4;

  // Typed constants so arithmetic and compares stay width-matched.
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(LZ_CAP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [SIG_W-1:0] SIG_MAX  = '1;
  localparam logic [SIG_W-1:0] SIG_ONE  = SIG_W'(1);
  // Significand after a carry out of the rounding increment: 1000.
  localparam logic [SIG_W-1:0] SIG_HALF = {1'b1, {(SIG_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round_unit.sv
// Combinational rounding and saturation of a pre-rounded exponent/significand.
module fp_round_unit
  import fp_normalizer_pkg::*;
(
  input  logic [EXP_W-1:0] i_exp,
  input  logic [SIG_W-1:0] i_sig,
  input  logic             i_round,
  input  logic             i_sat,
  output logic [EXP_W-1:0] o_exp,
  output logic [SIG_W-1:0] o_sig
);

  // Round half-up; a carry out of the significand bumps the exponent,
  // and running out of exponent range clamps to the largest code.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_exp = i_exp;
    o_sig = i_sig;
    if (i_sat) begin
      o_exp = EXP_MAX;
      o_sig = SIG_MAX;
    end else if (i_round) begin
      if (i_sig != SIG_MAX) begin
        o_sig = i_sig + SIG_ONE;
      end else if (i_exp != EXP_MAX) begin
        o_exp = i_exp + EXP_ONE;
        o_sig = SIG_HALF;
      end else begin
        o_exp = EXP_MAX;
        o_sig = SIG_MAX;
      end
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Converts a 12-bit sign-magnitude sample into a 3-bit exponent / 4-bit
// significand by shifting out leading zeros one bit per cycle, then rounding.
module fp_normalizer
  import fp_normalizer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [MAG_W-1:0] mag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [SIG_W-1:0] sig_out
);

  state_t             r_state;
  state_t             w_next;
  logic [MAG_W-1:0]   r_sreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic               r_sign_out;
  logic [EXP_W-1:0]   r_exp_out;
  logic [SIG_W-1:0]   r_sig_out;

  logic               w_load;
  logic               w_shift;
  logic               w_update;
  logic [EXP_W-1:0]   w_pre_exp;
  logic [EXP_W-1:0]   w_rnd_exp;
  logic [SIG_W-1:0]   w_rnd_sig;
  logic               w_sat;

  // State register; reset drops any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      r_state <= w_next;
    end
  end

  // Next-state decode plus handshake outputs and datapath strobes.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_update  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_sreg[MAG_W-1] || (r_cnt == CNT_CAP)) begin
          w_next = ST_ROUND;
        end else begin
          w_shift = 1'b1;
        end
      end
      ST_ROUND: begin
        w_update = 1'b1;
        w_next   = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Shift register and leading-zero counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, because their reset values are observable.
      r_sreg <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
    end else if (w_load) begin
      r_sreg <= mag_in;
      r_cnt  <= '0;
      r_sign <= sign_in;
    end else if (w_shift) begin
      r_sreg <= {r_sreg[MAG_W-2:0], 1'b0};
      r_cnt  <= r_cnt + CNT_ONE;
    end
  end

  // A count of 0 means the top bit was already set: too large to represent.
  assign w_sat     = (r_cnt == '0);
  // Exponent counts down from the cap; hitting the cap means a denormal-style 0.
  assign w_pre_exp = (r_cnt == CNT_CAP) ? '0 : EXP_W'(CNT_CAP - r_cnt);

  fp_round_unit u_round (
    .i_exp   (w_pre_exp),
    .i_sig   (r_sreg[MAG_W-1 -: SIG_W]),
    .i_round (r_sreg[MAG_W-1-SIG_W]),
    .i_sat   (w_sat),
    .o_exp   (w_rnd_exp),
    .o_sig   (w_rnd_sig)
  );

  // Result registers change only in ROUND and hold through DONE/IDLE/SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_out <= 1'b0;
      r_exp_out  <= '0;
      r_sig_out  <= '0;
    end else if (w_update) begin
      r_sign_out <= r_sign;
      r_exp_out  <= w_rnd_exp;
      r_sig_out  <= w_rnd_sig;
    end
  end

  assign sign_out = r_sign_out;
  assign exp_out  = r_exp_out;
  assign sig_out  = r_sig_out;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench: directed vectors, reset mid-scan, then random samples
// compared against an arithmetic reference model.
module tb_fp_normalizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [11:0] mag_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [2:0]  exp_out;
  logic [3:0]  sig_out;

  int errors = 0;
  int checks = 0;

  fp_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .mag_in    (mag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .sig_out   (sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count leading zeros, cap at 8, take the top 4 bits after
  // normalising, round half-up with carry into the exponent, clamp at 7/15.
  function automatic void model(input logic [11:0] mag, output int lat,
                                output int e, output int s);
    int lz;
    int lzc;
    int v;
    int rb;
    lz = 12;
    for (int b = 0; b < 12; b++) if (mag[b]) lz = 11 - b;
    lzc = (lz > 8) ? 8 : lz;
    lat = lzc + 2;
    if (lzc == 0) begin
      e = 7;
      s = 15;
      return;
    end
    v  = (int'(mag) << lzc) & 32'hFFF;
    s  = (v >> 8) & 15;
    rb = (v >> 7) & 1;
    e  = (lzc == 8) ? 0 : 8 - lzc;
    if (rb == 1) begin
      if (s < 15) s = s + 1;
      else if (e < 7) begin
        e = e + 1;
        s = 8;
      end else begin
        e = 7;
        s = 15;
      end
    end
  endfunction

  // Push one sample through, optionally pulsing in_valid while busy and
  // holding the result for several cycles before releasing it.
  task automatic run_sample(input logic [11:0] mag, input logic sign,
                            input int hold, input bit noise);
    int lat;
    int e;
    int s;
    int n;
    model(mag, lat, e, s);
    @(negedge clk);
    check("ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    mag_in   = mag;
    sign_in  = sign;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    mag_in   = 12'($urandom);
    sign_in  = 1'($urandom);
    check("ready_busy", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      if (noise) in_valid = 1'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(lat));
    check("sign", 32'(sign_out), 32'(sign));
    check("exp", 32'(exp_out), 32'(e));
    check("sig", 32'(sig_out), 32'(s));
    for (int h = 0; h < hold; h++) begin
      if (noise) in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_result", {23'd0, sign_out, exp_out, sig_out},
            {23'd0, sign, 3'(e), 4'(s)});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    check("retain_result", {23'd0, sign_out, exp_out, sig_out},
          {23'd0, sign, 3'(e), 4'(s)});
  endtask

  initial begin
    logic [11:0] rmag;
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    mag_in    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", {23'd0, sign_out, exp_out, sig_out}, 32'd0);

    // Directed vectors: typical, round carry, saturation, capped scan, zero.
    run_sample(12'h02C, 1'b1, 0, 1'b0);
    check("vec_02c_exp", 32'(exp_out), 32'b010);
    check("vec_02c_sig", 32'(sig_out), 32'b1011);
    run_sample(12'h07D, 1'b0, 1, 1'b0);
    run_sample(12'h7FF, 1'b1, 0, 1'b0);
    run_sample(12'h800, 1'b0, 0, 1'b0);
    run_sample(12'h00A, 1'b1, 0, 1'b0);
    run_sample(12'h000, 1'b0, 0, 1'b0);
    // Backpressure for 5 cycles with in_valid noise while busy.
    run_sample(12'h02C, 1'b1, 5, 1'b1);

    // Reset in the middle of a long scan.
    @(negedge clk);
    in_valid = 1'b1;
    mag_in   = 12'h003;
    sign_in  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", {23'd0, sign_out, exp_out, sig_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(12'h07D, 1'b1, 0, 1'b0);

    // Random samples with a random number of leading zeros.
    for (int k = 0; k < 40; k++) begin
      w    = $urandom_range(0, 12);
      rmag = 12'($urandom & ((1 << w) - 1));
      run_sample(rmag, 1'($urandom), $urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
